ucaspian_packet_encoder: RTL

- Downstream of ucaspian_core; consumes its output-side events: output fires, time updates, metric replies and clear-done acks.
- Arbitrates these events and serializes each one into a byte packet on a valid/ready stream toward the host I/O (UART/USB) transmitter.
- Returns the one-cycle completion handshakes the core expects: output_fire_sent, time_sent and ack_sent.

---
 rtl/ucaspian_packet_encoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ucaspian_packet_encoder.sv
// Serializes core output events (ack, metric, fire, time) into byte packets on a valid/ready stream.
// Optional UCASPIAN_TIME_DELTA_EN: short delta-time packets when the time step fits in one byte.
module ucaspian_packet_encoder #(
  parameter logic [7:0] OP_ACK    = 8'h01,
  parameter logic [7:0] OP_FIRE   = 8'h41,
  parameter logic [7:0] OP_TIME   = 8'h50,
  parameter logic [7:0] OP_METRIC = 8'h60
`ifdef UCASPIAN_TIME_DELTA_EN
  , parameter logic [7:0] OP_TIME_D = 8'h51
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  output_fire_addr,
  input  logic        output_fire_waiting,
  output logic        output_fire_sent,
  input  logic [31:0] time_current,
  input  logic        time_update,
  output logic        time_sent,
  input  logic [7:0]  metric_addr,
  input  logic [7:0]  metric_value,
  input  logic        metric_send,
  input  logic        clear_done,
  output logic        ack_sent,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        metric_drop
);

  typedef enum logic {IDLE, SEND} state_t;
  typedef enum logic [1:0] {K_ACK, K_METRIC, K_FIRE, K_TIME} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [39:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        m_pend_q, m_pend_d;
  logic [7:0]  m_addr_q, m_addr_d, m_val_q, m_val_d;
  logic        drop_q, drop_d;
  logic        ack_blk_q, ack_blk_d;
  logic        fire_sent_q, fire_sent_d, time_sent_q, time_sent_d, ack_sent_q, ack_sent_d;
`ifdef UCASPIAN_TIME_DELTA_EN
  logic [31:0] last_time_q, last_time_d;
  logic [31:0] delta;
  assign delta = time_current - last_time_q;
`endif

  logic ack_req, fire_req, time_req;
  // The core drops its level a cycle after *_sent, so mask each source during its own pulse.
  assign ack_req  = clear_done && !ack_blk_q && !ack_sent_q;
  assign fire_req = output_fire_waiting && !fire_sent_q;
  assign time_req = time_update && !time_sent_q;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    m_pend_d    = m_pend_q;
    m_addr_d    = m_addr_q;
    m_val_d     = m_val_q;
    drop_d      = drop_q;
    ack_blk_d   = ack_blk_q && clear_done;
    fire_sent_d = 1'b0;
    time_sent_d = 1'b0;
    ack_sent_d  = 1'b0;
`ifdef UCASPIAN_TIME_DELTA_EN
    last_time_d = last_time_q;
`endif

    if (metric_send) begin
      if (m_pend_q) begin
        drop_d = 1'b1;
      end else begin
        m_pend_d = 1'b1;
        m_addr_d = metric_addr;
        m_val_d  = metric_value;
      end
    end

    case (state_q)
      IDLE: begin
        if (ack_req) begin
          state_d   = SEND;
          kind_d    = K_ACK;
          sh_d      = {OP_ACK, 32'h0};
          cnt_d     = 3'd1;
          ack_blk_d = 1'b1;
        end else if (m_pend_q) begin
          state_d  = SEND;
          kind_d   = K_METRIC;
          sh_d     = {OP_METRIC, m_addr_q, m_val_q, 16'h0};
          cnt_d    = 3'd3;
          m_pend_d = 1'b0;
        end else if (fire_req) begin
          state_d = SEND;
          kind_d  = K_FIRE;
          sh_d    = {OP_FIRE, output_fire_addr, 24'h0};
          cnt_d   = 3'd2;
        end else if (time_req) begin
          state_d = SEND;
          kind_d  = K_TIME;
          sh_d    = {OP_TIME, time_current};
          cnt_d   = 3'd5;
`ifdef UCASPIAN_TIME_DELTA_EN
          last_time_d = time_current;
          if (delta[31:8] == 24'h0) begin
            sh_d  = {OP_TIME_D, delta[7:0], 24'h0};
            cnt_d = 3'd2;
          end
`endif
        end
      end
      SEND: begin
        if (tx_rdy) begin
          sh_d  = {sh_q[31:0], 8'h0};
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = IDLE;
            case (kind_q)
              K_ACK:    ack_sent_d  = 1'b1;
              K_FIRE:   fire_sent_d = 1'b1;
              K_TIME:   time_sent_d = 1'b1;
              K_METRIC: ;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      kind_q      <= K_ACK;
      sh_q        <= '0;
      cnt_q       <= '0;
      m_pend_q    <= 1'b0;
      m_addr_q    <= '0;
      m_val_q     <= '0;
      drop_q      <= 1'b0;
      ack_blk_q   <= 1'b0;
      fire_sent_q <= 1'b0;
      time_sent_q <= 1'b0;
      ack_sent_q  <= 1'b0;
`ifdef UCASPIAN_TIME_DELTA_EN
      last_time_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      m_pend_q    <= m_pend_d;
      m_addr_q    <= m_addr_d;
      m_val_q     <= m_val_d;
      drop_q      <= drop_d;
      ack_blk_q   <= ack_blk_d;
      fire_sent_q <= fire_sent_d;
      time_sent_q <= time_sent_d;
      ack_sent_q  <= ack_sent_d;
`ifdef UCASPIAN_TIME_DELTA_EN
      last_time_q <= last_time_d;
`endif
    end
  end

  assign tx_vld           = (state_q == SEND);
  assign tx_data          = sh_q[39:32];
  assign output_fire_sent = fire_sent_q;
  assign time_sent        = time_sent_q;
  assign ack_sent         = ack_sent_q;
  assign metric_drop      = drop_q;

endmodule
